uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 28 ++
 rtl/rx_data_sampler.sv | 33 +++
 rtl/uart_rx.sv | 129 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity types, legal oversampling ratios.
// Latency: none (package only).
// Backpressure: none (package only).
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_t;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   localparam logic [5:0] PRESCALE_8  = 6'd8;
   localparam logic [5:0] PRESCALE_16 = 6'd16;
   localparam logic [5:0] PRESCALE_32 = 6'd32;

   // Hard ceiling on a bit period so an illegal ratio can never stall the FSM
   localparam logic [5:0] EDGE_CNT_MAX = 6'd31;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/rx_data_sampler.sv
// Captures RX three times around mid-bit and presents the majority vote.
// Latency: vote valid from edge_cnt = prescale/2+2 until the next capture window.
// Backpressure: none; free-running alongside the receiver edge counter.
module rx_data_sampler
   import uart_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_in,
   input  logic [5:0] edge_cnt,
   input  logic [5:0] prescale,
   output logic       sampled_bit
);

   logic [5:0] mid;
   logic [2:0] samples;

   assign mid = {1'b0, prescale[5:1]};

   // Grab the line one edge before, at, and one edge after the bit centre
   always_ff @(posedge clk) begin
      if (rst) begin
         samples <= 3'b000;
      end else begin
         if (edge_cnt == mid - 6'd1) samples[0] <= rx_in;
         if (edge_cnt == mid)        samples[1] <= rx_in;
         if (edge_cnt == mid + 6'd1) samples[2] <= rx_in;
      end
   end

   assign sampled_bit = majority3(samples[0], samples[1], samples[2]);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/parity/stop framing with error pulses.
// Latency: Data_Valid/Par_Err/Stp_Err pulse one cycle after the last edge of the relevant bit.
// Backpressure: none; each result is a single-cycle pulse, P_DATA holds until the next good frame.
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8
)
(
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic [5:0]            Prescale,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  Data_Valid,
   output logic                  Par_Err,
   output logic                  Stp_Err
);

   localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

   uart_state_t           state;
   logic [5:0]            edge_cnt;
   logic [BCW-1:0]        bit_cnt;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic [5:0]            prescale_q;
   logic                  par_en_q;
   logic                  par_typ_q;
   logic                  par_err_seen;
   logic                  sampled_bit;
   logic                  bit_end;
   logic                  exp_parity;

   rx_data_sampler u_sampler (
      .clk         (CLK),
      .rst         (RST),
      .rx_in       (RX_IN),
      .edge_cnt    (edge_cnt),
      .prescale    (prescale_q),
      .sampled_bit (sampled_bit)
   );

   // A bit ends at the programmed ratio, or at the hard ceiling for illegal ratios
   assign bit_end    = (edge_cnt == prescale_q - 6'd1) || (edge_cnt == EDGE_CNT_MAX);
   // Even: parity bit equals XOR of data; odd: its complement
   assign exp_parity = (^shift_reg) ^ par_typ_q;

   // Frame FSM with bit timing, shift register and registered result pulses
   always_ff @(posedge CLK) begin
      if (RST) begin
         state        <= IDLE;
         edge_cnt     <= 6'd0;
         bit_cnt      <= '0;
         shift_reg    <= '0;
         prescale_q   <= PRESCALE_8;
         par_en_q     <= 1'b0;
         par_typ_q    <= PAR_EVEN;
         par_err_seen <= 1'b0;
         P_DATA       <= '0;
         Data_Valid   <= 1'b0;
         Par_Err      <= 1'b0;
         Stp_Err      <= 1'b0;
      end else begin
         Data_Valid <= 1'b0;
         Par_Err    <= 1'b0;
         Stp_Err    <= 1'b0;
         edge_cnt   <= bit_end ? 6'd0 : edge_cnt + 6'd1;

         case (state)
            IDLE: begin
               // Configuration is only taken while idle, so it stays frozen for a frame
               edge_cnt     <= 6'd0;
               bit_cnt      <= '0;
               prescale_q   <= Prescale;
               par_en_q     <= PAR_EN;
               par_typ_q    <= PAR_TYP;
               par_err_seen <= 1'b0;
               if (!RX_IN) begin
                  // Detection cycle is edge 0 of the start bit
                  state    <= START;
                  edge_cnt <= 6'd1;
               end
            end
            START: begin
               if (bit_end) state <= sampled_bit ? IDLE : DATA;
            end
            DATA: begin
               if (bit_end) begin
                  shift_reg <= {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
                  if (bit_cnt == LAST_BIT) begin
                     bit_cnt <= '0;
                     state   <= par_en_q ? PARITY : STOP;
                  end else begin
                     bit_cnt <= bit_cnt + BCW'(1);
                  end
               end
            end
            PARITY: begin
               if (bit_end) begin
                  if (sampled_bit != exp_parity) begin
                     Par_Err      <= 1'b1;
                     par_err_seen <= 1'b1;
                  end
                  state <= STOP;
               end
            end
            STOP: begin
               if (bit_end) begin
                  if (!sampled_bit) begin
                     Stp_Err <= 1'b1;
                  end else if (!par_err_seen) begin
                     P_DATA     <= shift_reg;
                     Data_Valid <= 1'b1;
                  end
                  state <= IDLE;
               end
            end
            default: begin
               state    <= IDLE;
               edge_cnt <= 6'd0;
            end
         endcase
      end
   end

endmodule
